mix_backward_dot: RTL and testbench

MIX_BACKWARD_DOT -- requirements
Module: mix_backward_dot

---
 rtl/mix_backward_dot.sv | 214 +++++++++++++++++++++
 tb/tb_mix_backward_dot.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mix_backward_dot.sv
// Backward dot product: d_out = sat(floor(W_T * d_in / 2^FRAC_W)), streaming W_T
// rows from a 1-cycle-latency RAM through a two-stage multiply/accumulate pipeline.
module mix_backward_dot #(
    parameter int ADDR_WIDTH = 9,
    parameter int FRAC_W     = 8,
    parameter int HID_DIM    = 24,
    parameter int DATA_N     = 8,
    parameter int N_LEN_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         run,
    input  logic [1:0]                   sel,
    input  logic [HID_DIM*N_LEN_W-1:0]   d_in,
    output logic [ADDR_WIDTH-1:0]        raddr,
    input  logic [DATA_N*N_LEN_W-1:0]    rdata,
    output logic [HID_DIM*N_LEN_W-1:0]   d_out,
    output logic                         valid
);

    localparam int N_WORDS = HID_DIM * HID_DIM / DATA_N;
    localparam int CPR     = HID_DIM / DATA_N;
    localparam int ACC_W   = 2 * N_LEN_W + $clog2(HID_DIM);
    localparam int ROW_W   = $clog2(HID_DIM);
    localparam int COL_W   = (CPR > 1) ? $clog2(CPR) : 1;
    localparam int CNT_W   = $clog2(N_WORDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [COL_W-1:0]        LAST_COL = COL_W'(CPR - 1);
    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(N_WORDS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((64'sd1 <<< (N_LEN_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

    logic [1:0]                 r_state;
    logic [HID_DIM*N_LEN_W-1:0] r_din;
    logic [ADDR_WIDTH-1:0]      r_raddr;
    logic [CNT_W-1:0]           r_cnt;
    logic [ROW_W-1:0]           r_row;
    logic [COL_W-1:0]           r_col;
    logic                       r_drain;
    logic                       r_s0_v;
    logic [ROW_W-1:0]           r_s0_row;
    logic [COL_W-1:0]           r_s0_col;
    logic                       r_s1_v;
    logic [ROW_W-1:0]           r_s1_row;
    logic [COL_W-1:0]           r_s1_col;
    logic signed [ACC_W-1:0]    r_s1_sum;
    logic signed [ACC_W-1:0]    r_acc;
    logic [HID_DIM*N_LEN_W-1:0] r_res;
    logic [HID_DIM*N_LEN_W-1:0] r_dout;
    logic                       r_valid;

    logic [ADDR_WIDTH-1:0]      w_base;
    logic                       w_busy;
    logic                       w_wr;
    logic signed [ACC_W-1:0]    w_s1_sum;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic signed [ACC_W-1:0]    w_shift;
    logic [N_LEN_W-1:0]         w_sat;
    logic [HID_DIM*N_LEN_W-1:0] w_res_next;

    assign w_base = ADDR_WIDTH'(sel) * ADDR_WIDTH'(N_WORDS);
    assign w_busy = (r_state == S_READ) || (r_state == S_DRAIN);
    assign w_wr   = r_s1_v && w_busy && (r_s1_col == LAST_COL);
    assign raddr  = r_raddr;
    assign d_out  = r_dout;
    assign valid  = r_valid;

    // Stage 1: sum of the DATA_N products of the RAM word with its d_in chunk
    always_comb begin
        w_s1_sum = '0;
        for (int j = 0; j < DATA_N; j++) begin
            w_s1_sum = w_s1_sum
                + (ACC_W'($signed(rdata[j*N_LEN_W +: N_LEN_W]))
                * ACC_W'($signed(r_din[(int'(r_s0_col)*DATA_N + j)*N_LEN_W +: N_LEN_W])));
        end
    end

    // Stage 2: accumulate (restarting at chunk 0), then floor-shift and saturate
    always_comb begin
        if (r_s1_col == '0) begin
            w_acc_next = r_s1_sum;
        end else begin
            w_acc_next = r_acc + r_s1_sum;
        end
        w_shift = w_acc_next >>> FRAC_W;
        if (w_shift > SAT_MAX) begin
            w_sat = SAT_MAX[N_LEN_W-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_sat = SAT_MIN[N_LEN_W-1:0];
        end else begin
            w_sat = w_shift[N_LEN_W-1:0];
        end
    end

    // Result buffer with the row finishing this cycle merged in, so DONE can load it directly
    always_comb begin
        w_res_next = r_res;
        if (w_wr) begin
            w_res_next[int'(r_s1_row)*N_LEN_W +: N_LEN_W] = w_sat;
        end else begin
            w_res_next = r_res;
        end
    end

    // Control FSM, address generation and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_din   <= '0;
            r_raddr <= '0;
            r_cnt   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_drain <= 1'b0;
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_raddr <= '0;
                    if (run) begin
                        r_din <= d_in;
                        if (sel == 2'd3) begin
                            r_state <= S_DONE;
                            r_dout  <= '0;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                            r_raddr <= w_base;
                            r_cnt   <= '0;
                            r_row   <= '0;
                            r_col   <= '0;
                        end
                    end
                end
                S_READ: begin
                    if (!run) begin
                        r_state <= S_IDLE;
                        r_raddr <= '0;
                    end else if (r_cnt == LAST_CNT) begin
                        r_state <= S_DRAIN;
                        r_raddr <= '0;
                        r_drain <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_raddr <= r_raddr + ADDR_WIDTH'(1);
                        if (r_col == LAST_COL) begin
                            r_col <= '0;
                            r_row <= r_row + ROW_W'(1);
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!run) begin
                        r_state <= S_IDLE;
                    end else if (r_drain) begin
                        r_state <= S_DONE;
                        r_dout  <= w_res_next;
                        r_valid <= 1'b1;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_raddr <= '0;
                    if (!run) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_raddr <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline registers; valid bits drop on abort so stale partial sums never land
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_v   <= 1'b0;
            r_s0_row <= '0;
            r_s0_col <= '0;
            r_s1_v   <= 1'b0;
            r_s1_row <= '0;
            r_s1_col <= '0;
            r_s1_sum <= '0;
            r_acc    <= '0;
            r_res    <= '0;
        end else begin
            r_s0_v   <= (r_state == S_READ) && run;
            r_s0_row <= r_row;
            r_s0_col <= r_col;
            r_s1_v   <= r_s0_v && w_busy && run;
            r_s1_row <= r_s0_row;
            r_s1_col <= r_s0_col;
            r_s1_sum <= w_s1_sum;
            if (r_s1_v && w_busy) begin
                r_acc <= w_acc_next;
            end
            r_res    <= w_res_next;
        end
    end

endmodule

// File: tb/tb_mix_backward_dot.sv
// Directed bench for mix_backward_dot with a 1-cycle-latency RAM model and
// hand-derived expected result vectors.
module tb_mix_backward_dot;

    localparam int HID  = 24;
    localparam int DN   = 8;
    localparam int NW   = 72;
    localparam int VW   = HID * 16;

    logic             clk;
    logic             rst;
    logic             run;
    logic [1:0]       sel;
    logic [VW-1:0]    d_in;
    logic [8:0]       raddr;
    logic [DN*16-1:0] rdata;
    logic [VW-1:0]    d_out;
    logic             valid;

    logic [DN*16-1:0] mem [0:3*NW-1];

    int n_checks = 0;
    int n_errors = 0;

    logic [VW-1:0] v_ramp;
    logic [VW-1:0] v_junk;
    logic [VW-1:0] v_7fff;
    logic [VW-1:0] v_8000;
    logic [VW-1:0] v_ffff;
    logic [VW-1:0] v_fff4;
    logic [VW-1:0] v_ident;

    mix_backward_dot dut (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .sel   (sel),
        .d_in  (d_in),
        .raddr (raddr),
        .rdata (rdata),
        .d_out (d_out),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rdata <= (raddr < 9'd216) ? mem[raddr] : '0;
    end

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // kind: 0 identity (1.0 on diagonal), 1 all 0x7FFF, 2 all 0x0080, 3 zeros
    task automatic fill(input int s, input int kind);
        logic [15:0] v;
        for (int r = 0; r < HID; r++)
            for (int c = 0; c < HID / DN; c++)
                for (int j = 0; j < DN; j++) begin
                    case (kind)
                        0: v = (c * DN + j == r) ? 16'h0100 : 16'h0000;
                        1: v = 16'h7FFF;
                        2: v = 16'h0080;
                        default: v = 16'h0000;
                    endcase
                    mem[s * NW + r * (HID / DN) + c][j*16 +: 16] = v;
                end
    endtask

    task automatic start(input logic [1:0] s, input logic [VW-1:0] v);
        run  = 1'b1;
        sel  = s;
        d_in = v;
    endtask

    task automatic stop_run();
        run = 1'b0;
        cyc(2);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; sel = 2'd0; d_in = '0;
        for (int k = 0; k < HID; k++) begin
            v_ramp[k*16 +: 16]  = 16'(k * 256);
            v_ident[k*16 +: 16] = 16'(k * 256);
            v_junk[k*16 +: 16]  = 16'h1234;
            v_7fff[k*16 +: 16]  = 16'h7FFF;
            v_8000[k*16 +: 16]  = 16'h8000;
            v_ffff[k*16 +: 16]  = 16'hFFFF;
            v_fff4[k*16 +: 16]  = 16'hFFF4;
        end
        fill(0, 3); fill(1, 0); fill(2, 3);
        cyc(3);
        chk("reset_raddr", VW'(raddr), '0);
        chk("reset_valid", VW'(valid), '0);
        chk("reset_dout", d_out, '0);
        rst = 1'b0;
        cyc(1);

        // identity, sel=1, inputs scrambled after cycle 0
        start(2'd1, v_ramp);
        cyc(1);
        sel = 2'd2; d_in = v_junk;
        chk("raddr_c1", VW'(raddr), VW'(72));
        for (int n = 2; n <= NW; n++) begin
            cyc(1);
            chk("raddr_seq", VW'(raddr), VW'(72 + n - 1));
        end
        cyc(2);
        chk("valid_c74", VW'(valid), '0);
        cyc(1);
        chk("valid_c75", VW'(valid), VW'(1));
        chk("ident_dout", d_out, v_ident);
        chk("done_raddr", VW'(raddr), '0);
        cyc(3);
        chk("hold_valid", VW'(valid), VW'(1));
        chk("hold_dout", d_out, v_ident);
        chk("hold_raddr", VW'(raddr), '0);
        run = 1'b0;
        cyc(1);
        chk("drop_valid", VW'(valid), '0);
        chk("drop_dout", d_out, v_ident);
        cyc(1);

        // sel=3: no reads, zero result, valid in cycle 1
        start(2'd3, v_ramp);
        cyc(1);
        chk("sel3_valid", VW'(valid), VW'(1));
        chk("sel3_dout", d_out, '0);
        chk("sel3_raddr", VW'(raddr), '0);
        cyc(2);
        chk("sel3_raddr2", VW'(raddr), '0);
        stop_run();

        // positive saturation
        fill(0, 1);
        start(2'd0, v_7fff);
        cyc(75);
        chk("satp_valid", VW'(valid), VW'(1));
        chk("satp_dout", d_out, v_7fff);
        stop_run();

        // negative saturation
        start(2'd0, v_8000);
        cyc(75);
        chk("satn_valid", VW'(valid), VW'(1));
        chk("satn_dout", d_out, v_8000);
        stop_run();

        // floor of a negative sum: -3072/256 = -12
        fill(2, 2);
        start(2'd2, v_ffff);
        cyc(75);
        chk("floor_valid", VW'(valid), VW'(1));
        chk("floor_dout", d_out, v_fff4);
        stop_run();

        // abort in cycle 40
        start(2'd1, v_ramp);
        cyc(40);
        chk("abort_raddr40", VW'(raddr), VW'(111));
        run = 1'b0;
        cyc(1);
        chk("abort_idle_raddr", VW'(raddr), '0);
        for (int n = 0; n < 40; n++) begin
            chk("abort_valid", VW'(valid), '0);
            cyc(1);
        end
        chk("abort_dout", d_out, v_fff4);
        start(2'd1, v_ramp);
        cyc(74);
        chk("rerun_valid74", VW'(valid), '0);
        cyc(1);
        chk("rerun_valid", VW'(valid), VW'(1));
        chk("rerun_dout", d_out, v_ident);
        stop_run();

        // reset in cycle 30 of a run
        start(2'd1, v_ramp);
        cyc(30);
        rst = 1'b1;
        cyc(1);
        chk("rst_raddr", VW'(raddr), '0);
        chk("rst_valid", VW'(valid), '0);
        chk("rst_dout", d_out, '0);
        rst = 1'b0; run = 1'b0;
        cyc(1);
        start(2'd1, v_ramp);
        cyc(1);
        chk("post_rst_raddr", VW'(raddr), VW'(72));
        cyc(74);
        chk("post_rst_valid", VW'(valid), VW'(1));
        chk("post_rst_dout", d_out, v_ident);
        stop_run();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
